// File: rtl/sample_scheduler_pkg.sv
// Shared raster definitions for the sample scheduler.
//   sched_state_t  : scheduler FSM states (IDLE / WALK / DRAIN)
//   coord_t        : one signed sample/box coordinate at the default width
//   coord_pair_t   : (x, y) coordinate pair
//   AXIS_X/AXIS_Y  : index of each axis inside the [1:0] coordinate ports
//   drain_cnt_w()  : width of a counter that spans 0 .. depth-1
package sample_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    localparam int COORD_W = 24;

    typedef logic signed [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } coord_pair_t;

    localparam int AXIS_X = 0;
    localparam int AXIS_Y = 1;

    function automatic int drain_cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sample_scheduler_stepper.sv
// bbox_stepper: walks a bounding box in raster order.
//   clk, rst          : clock, asynchronous active-low reset
//   load              : latch ll/ur/stride and move to the lower-left corner
//   advance           : step to the next sample position
//   ll_in, ur_in      : box corners (x at AXIS_X, y at AXIS_Y), signed
//   stride_in         : unsigned subsample step
//   pos               : current sample position
//   last              : current position is the final sample of the box
//   degenerate        : the box on ll_in/ur_in contains no samples
module bbox_stepper
    import sample_scheduler_pkg::*;
#(
    parameter int SIGFIG = 24
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     advance,
    input  logic signed [SIGFIG-1:0] ll_in [1:0],
    input  logic signed [SIGFIG-1:0] ur_in [1:0],
    input  logic        [SIGFIG-1:0] stride_in,
    output logic signed [SIGFIG-1:0] pos [1:0],
    output logic                     last,
    output logic                     degenerate
);

    localparam int EXT_W = SIGFIG + 1;

    logic signed [SIGFIG-1:0] ll_x;
    logic signed [SIGFIG-1:0] ur_x;
    logic signed [SIGFIG-1:0] ur_y;
    logic        [SIGFIG-1:0] stride_q;
    logic signed [SIGFIG-1:0] x_q;
    logic signed [SIGFIG-1:0] y_q;

    logic signed [EXT_W-1:0] stride_ext;
    logic signed [EXT_W-1:0] x_sum;
    logic signed [EXT_W-1:0] y_sum;
    logic signed [EXT_W-1:0] ur_x_ext;
    logic signed [EXT_W-1:0] ur_y_ext;
    logic                    wrap_x;
    logic                    wrap_y;

    // One extra bit keeps x+stride / y+stride from wrapping near the top of
    // the coordinate range, so the overshoot tests stay correct.
    assign stride_ext = $signed({1'b0, stride_q});
    assign x_sum      = $signed({x_q[SIGFIG-1], x_q}) + stride_ext;
    assign y_sum      = $signed({y_q[SIGFIG-1], y_q}) + stride_ext;
    assign ur_x_ext   = $signed({ur_x[SIGFIG-1], ur_x});
    assign ur_y_ext   = $signed({ur_y[SIGFIG-1], ur_y});

    assign wrap_x = (x_sum > ur_x_ext);
    assign wrap_y = (y_sum > ur_y_ext);
    assign last   = wrap_x && wrap_y;

    assign degenerate = (ur_in[AXIS_X] < ll_in[AXIS_X]) ||
                        (ur_in[AXIS_Y] < ll_in[AXIS_Y]);

    assign pos[AXIS_X] = x_q;
    assign pos[AXIS_Y] = y_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ll_x     <= '0;
            ur_x     <= '0;
            ur_y     <= '0;
            stride_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
        end else if (load) begin
            ll_x     <= ll_in[AXIS_X];
            ur_x     <= ur_in[AXIS_X];
            ur_y     <= ur_in[AXIS_Y];
            stride_q <= stride_in;
            x_q      <= ll_in[AXIS_X];
            y_q      <= ll_in[AXIS_Y];
        end else if (advance) begin
            if (wrap_x) begin
                x_q <= ll_x;
                y_q <= y_sum[SIGFIG-1:0];
            end else begin
                x_q <= x_sum[SIGFIG-1:0];
            end
        end
    end

endmodule

// File: rtl/sample_scheduler.sv
// sample_scheduler: accepts triangle bounding boxes and issues one subsample
// location per non-halted cycle in raster order, then waits for the last
// sample to clear the downstream sample-test pipeline before signalling done.
//   clk             : clock
//   rst             : asynchronous active-low reset
//   box_valid_R14H  : box offered
//   box_ready_R14H  : box accepted this cycle (IDLE only)
//   box_ll_R14S     : lower-left corner (x,y)
//   box_ur_R14S     : upper-right corner (x,y), inclusive
//   stride_R14U     : subsample step
//   halt_RnnnnH     : downstream stall, freezes walking and draining
//   sample_R16S     : current sample location (x,y)
//   validSamp_R16H  : sample_R16S is valid
//   tri_done_R18H   : pulse as the last sample leaves the sample-test pipeline
module sample_scheduler
    import sample_scheduler_pkg::*;
#(
    parameter int SIGFIG     = 24,
    parameter int RADIX      = 10,
    parameter int PIPE_DEPTH = 2
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     box_valid_R14H,
    output logic                     box_ready_R14H,
    input  logic signed [SIGFIG-1:0] box_ll_R14S [1:0],
    input  logic signed [SIGFIG-1:0] box_ur_R14S [1:0],
    input  logic        [SIGFIG-1:0] stride_R14U,
    input  logic                     halt_RnnnnH,
    output logic signed [SIGFIG-1:0] sample_R16S [1:0],
    output logic                     validSamp_R16H,
    output logic                     tri_done_R18H
);

    localparam int CNT_W = drain_cnt_w(PIPE_DEPTH);

    if (PIPE_DEPTH < 1) begin : g_bad_depth
        $error("sample_scheduler: PIPE_DEPTH must be at least 1");
    end
    if (RADIX >= SIGFIG) begin : g_bad_radix
        $error("sample_scheduler: RADIX must leave integer bits in SIGFIG");
    end

    sched_state_t     state;
    sched_state_t     state_next;
    logic [CNT_W-1:0] drain_cnt;
    logic             drain_end;
    logic             load;
    logic             advance;
    logic             last;
    logic             degenerate;

    assign load      = (state == ST_IDLE) && box_valid_R14H;
    assign advance   = (state == ST_WALK) && !halt_RnnnnH;
    // Final non-halted drain cycle: the last sample is leaving the pipeline now.
    assign drain_end = (drain_cnt == CNT_W'(PIPE_DEPTH - 1));

    bbox_stepper #(
        .SIGFIG (SIGFIG)
    ) u_stepper (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (advance),
        .ll_in      (box_ll_R14S),
        .ur_in      (box_ur_R14S),
        .stride_in  (stride_R14U),
        .pos        (sample_R16S),
        .last       (last),
        .degenerate (degenerate)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (box_valid_R14H) begin
                    state_next = degenerate ? ST_DRAIN : ST_WALK;
                end
            end
            ST_WALK: begin
                if (!halt_RnnnnH && last) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!halt_RnnnnH && drain_end) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        box_ready_R14H = 1'b0;
        validSamp_R16H = 1'b0;
        tri_done_R18H  = 1'b0;
        case (state)
            ST_IDLE:  box_ready_R14H = 1'b1;
            ST_WALK:  validSamp_R16H = !halt_RnnnnH;
            ST_DRAIN: tri_done_R18H  = !halt_RnnnnH && drain_end;
            default: ;
        endcase
    end

    // Counts non-halted DRAIN cycles; idles at zero outside DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt <= '0;
        end else if (state != ST_DRAIN) begin
            drain_cnt <= '0;
        end else if (!halt_RnnnnH) begin
            drain_cnt <= drain_end ? '0 : drain_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 Parameter SIGFIG, default 24, bits in sample/box coordinates.
REQ-002 Parameter RADIX, default 10, fraction bits of coordinates.
REQ-003 Parameter PIPE_DEPTH, default 2, latency of the downstream sample-test pipeline.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 box_valid_R14H  input  1  triangle bounding box offered.
REQ-007 box_ready_R14H  output  1  scheduler accepts a box this cycle.
REQ-008 box_ll_R14S[1:0]  input  SIGFIG each, signed  lower-left corner (x,y), subsample-aligned.
REQ-009 box_ur_R14S[1:0]  input  SIGFIG each, signed  upper-right corner (x,y), inclusive.
REQ-010 stride_R14U  input  SIGFIG, unsigned  subsample step, nonzero, latched with box.
REQ-011 halt_RnnnnH  input  1  downstream stall; scheduler must not advance.
REQ-012 sample_R16S[1:0]  output  SIGFIG each, signed  current sample location.
REQ-013 validSamp_R16H  output  1  sample_R16S valid this cycle.
REQ-014 tri_done_R18H  output  1  one-cycle pulse when the last sample of the box leaves the sample-test pipeline.

Function
REQ-015 FSM states IDLE, WALK, DRAIN; encoding free.
REQ-016 IDLE: box_ready_R14H=1; on box_valid_R14H&&box_ready_R14H latch ll, ur, stride, load sample=ll, go WALK next cycle.
REQ-017 box_ready_R14H SHALL be 0 in WALK and DRAIN.
REQ-018 WALK: validSamp_R16H=1 unless halt_RnnnnH=1, in which case validSamp_R16H=0 and sample_R16S holds.
REQ-019 Advance (WALK, halt low): x+=stride; if x+stride>ur_x then x=ll_x and y+=stride.
REQ-020 If x wraps and y+stride>ur_y, the current sample is the last; after issuing it go DRAIN, validSamp_R16H=0 next cycle.
REQ-021 Comparisons use SIGFIG+1-bit signed sums; no overflow wrap permitted for in-range boxes.
REQ-022 Degenerate box (ur_x<ll_x or ur_y<ll_y): no samples issued, go directly to DRAIN.
REQ-023 Single-sample box (ll==ur): exactly one sample issued.
REQ-024 DRAIN: count PIPE_DEPTH non-halted cycles after last issue, then pulse tri_done_R18H for one cycle and return IDLE.
REQ-025 halt_RnnnnH freezes the DRAIN counter as well as WALK.
REQ-026 Samples issue in raster order, bottom row first, left to right; one sample per non-halted WALK cycle.
REQ-027 box_valid_R14H while not ready is ignored; box inputs held by producer until accepted.

Reset
REQ-028 rst low: state=IDLE, sample_R16S=0, validSamp_R16H=0, tri_done_R18H=0, box_ready_R14H=1 after release, latched box/stride=0, drain counter=0.
REQ-029 Reset mid-WALK/DRAIN aborts the box; no tri_done_R18H pulse produced.

Structure
REQ-030 State enum and coordinate typedef (signed [SIGFIG-1:0] pair) reside in the shared raster package.
REQ-031 Single sub-module bbox_stepper: holds x/y registers, computes next position and last-sample flag; FSM and drain counter in top.

Verification
REQ-032 ll=(0,0), ur=(2048,1024), stride=1024 -> samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on 6 consecutive cycles; tri_done 2 cycles after last.
REQ-033 Same box, halt high 3 cycles after 2nd sample -> validSamp low 3 cycles, sample holds (1024,0), sequence resumes unchanged, tri_done delayed 3 cycles.
REQ-034 ll=ur=(512,512) -> exactly one sample (512,512); tri_done PIPE_DEPTH cycles later; box_ready high next cycle.
REQ-035 ll=(1024,0), ur=(0,0) -> zero validSamp cycles; tri_done after PIPE_DEPTH cycles.
REQ-036 rst asserted during 4th sample of REQ-032 box -> outputs zero immediately, no tri_done, next box accepted normally.
REQ-037 Negative box ll=(-1024,-1024), ur=(0,0), stride=512 -> 9 samples, last (0,0), no overflow.
